// File: rtl/taillight_if.sv
// Request and lamp-drive signals between the driver-input synchronisers
// and the tail-light sequencer.
interface taillight_if;
   logic left;
   logic right;
   logic hazard;
   logic brake;
   logic la;
   logic lb;
   logic lc;
   logic ra;
   logic rb;
   logic rc;
   logic busy;

   modport master (
      output left, right, hazard, brake,
      input  la, lb, lc, ra, rb, rc, busy
   );

   modport slave (
      input  left, right, hazard, brake,
      output la, lb, lc, ra, rb, rc, busy
   );
endinterface

// File: rtl/taillight_sequencer.sv
// Tail-light sequencer: arbitrates turn, hazard and brake requests and paces
// the sweep animation with a free-running prescaler of TICK_DIV cycles per step.
module taillight_sequencer #(
   parameter int TICK_DIV = 4
) (
   input logic       clk,
   input logic       reset,
   taillight_if.slave bus
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      L1   = 4'd1,
      L2   = 4'd2,
      L3   = 4'd3,
      R1   = 4'd4,
      R2   = 4'd5,
      R3   = 4'd6,
      HON  = 4'd7,
      HOFF = 4'd8
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             haz;
   logic [2:0]       left_pat;
   logic [2:0]       right_pat;

   assign tick = (cnt == CNT_LAST);
   assign haz  = bus.hazard | (bus.left & bus.right);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
         if (tick) begin
            if (state == HON) begin
               state <= HOFF;
            end else if (haz) begin
               state <= HON;
            end else begin
               // haz is low here, so left and right are never both set in IDLE
               case (state)
                  IDLE: begin
                     if (bus.left)       state <= L1;
                     else if (bus.right) state <= R1;
                     else                state <= IDLE;
                  end
                  L1:      state <= L2;
                  L2:      state <= L3;
                  L3:      state <= IDLE;
                  R1:      state <= R2;
                  R2:      state <= R3;
                  R3:      state <= IDLE;
                  HOFF:    state <= IDLE;
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   // NOTE: both patterns get a default before the case so no latch is inferred.
   always_comb begin
      left_pat  = 3'b000;
      right_pat = 3'b000;

      case (state)
         L1:      left_pat = 3'b100;
         L2:      left_pat = 3'b110;
         L3:      left_pat = 3'b111;
         default: left_pat = (bus.brake || state == HON) ? 3'b111 : 3'b000;
      endcase

      // Brake overrides only a side that is not sweeping
      case (state)
         R1:      right_pat = 3'b100;
         R2:      right_pat = 3'b110;
         R3:      right_pat = 3'b111;
         default: right_pat = (bus.brake || state == HON) ? 3'b111 : 3'b000;
      endcase
   end

   assign bus.la   = left_pat[2];
   assign bus.lb   = left_pat[1];
   assign bus.lc   = left_pat[0];
   assign bus.ra   = right_pat[2];
   assign bus.rb   = right_pat[1];
   assign bus.rc   = right_pat[0];
   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed bench for taillight_sequencer: one DUT with TICK_DIV = 4 and one
// with TICK_DIV = 1, each scenario in its own task with hand-derived values.
module tb_taillight_sequencer;

   logic clk        = 1'b0;
   logic reset      = 1'b1;
   logic reset_fast = 1'b1;
   int   checks     = 0;
   int   errors     = 0;

   taillight_if bus ();
   taillight_if bus_fast ();

   taillight_sequencer #(.TICK_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   taillight_sequencer #(.TICK_DIV(1)) dut_fast (
      .clk   (clk),
      .reset (reset_fast),
      .bus   (bus_fast.slave)
   );

   always #5 clk = ~clk;

   logic [2:0] lamp_l, lamp_r, fast_l, fast_r;
   assign lamp_l = {bus.la, bus.lb, bus.lc};
   assign lamp_r = {bus.ra, bus.rb, bus.rc};
   assign fast_l = {bus_fast.la, bus_fast.lb, bus_fast.lc};
   assign fast_r = {bus_fast.ra, bus_fast.rb, bus_fast.rc};

   // Advance n rising edges and settle 1 time unit past the last one
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Two reset edges; on return the next rising edge is edge 1 with cnt = 0
   task automatic apply_reset();
      bus.left   = 1'b0;
      bus.right  = 1'b0;
      bus.hazard = 1'b0;
      bus.brake  = 1'b0;
      reset      = 1'b1;
      wait_edges(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      wait_edges(2);
      checks++;
      if ({lamp_l, lamp_r, bus.busy} !== 7'b000000_0) begin
         $display("FAIL reset_idle: got l=%b r=%b busy=%b, want l=000 r=000 busy=0",
                  lamp_l, lamp_r, bus.busy);
         errors++;
      end
      checks++;
      if ({fast_l, fast_r, bus_fast.busy} !== 7'b000000_0) begin
         $display("FAIL reset_idle_fast: got l=%b r=%b busy=%b, want l=000 r=000 busy=0",
                  fast_l, fast_r, bus_fast.busy);
         errors++;
      end
      bus.brake = 1'b1;
      #1;
      checks++;
      if ({lamp_l, lamp_r, bus.busy} !== 7'b111111_0) begin
         $display("FAIL reset_brake: got l=%b r=%b busy=%b, want l=111 r=111 busy=0",
                  lamp_l, lamp_r, bus.busy);
         errors++;
      end
      bus.brake = 1'b0;
   endtask

   task automatic test_left_sweep();
      logic [2:0] exp_l;
      logic       exp_busy;
      apply_reset();
      bus.left = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         wait_edges(1);
         case (e / 4)
            1:       exp_l = 3'b100;
            2:       exp_l = 3'b110;
            3:       exp_l = 3'b111;
            5:       exp_l = 3'b100;
            default: exp_l = 3'b000;
         endcase
         exp_busy = !(e < 4 || (e >= 16 && e <= 19));
         checks++;
         if (lamp_l !== exp_l || lamp_r !== 3'b000 || bus.busy !== exp_busy) begin
            $display("FAIL left_sweep edge %0d: got l=%b r=%b busy=%b, want l=%b r=000 busy=%b",
                     e, lamp_l, lamp_r, bus.busy, exp_l, exp_busy);
            errors++;
         end
      end
      bus.left = 1'b0;
   endtask

   task automatic test_request_drop();
      logic [2:0] exp_r;
      logic       exp_busy;
      apply_reset();
      bus.right = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         wait_edges(1);
         if (e == 5) bus.right = 1'b0;
         if (e % 4 == 0) begin
            case (e)
               4:       exp_r = 3'b100;
               8:       exp_r = 3'b110;
               12:      exp_r = 3'b111;
               default: exp_r = 3'b000;
            endcase
            exp_busy = (e <= 12);
            checks++;
            if (lamp_r !== exp_r || lamp_l !== 3'b000 || bus.busy !== exp_busy) begin
               $display("FAIL request_drop edge %0d: got l=%b r=%b busy=%b, want l=000 r=%b busy=%b",
                        e, lamp_l, lamp_r, bus.busy, exp_r, exp_busy);
               errors++;
            end
         end
      end
   endtask

   task automatic test_hazard_abort();
      logic [2:0] exp_l, exp_r;
      logic       exp_busy;
      logic       do_chk;
      apply_reset();
      bus.left = 1'b1;
      for (int e = 1; e <= 28; e++) begin
         wait_edges(1);
         if (e == 9) bus.hazard = 1'b1;
         if (e == 21) begin
            bus.hazard = 1'b0;
            bus.left   = 1'b0;
         end
         if (e == 17) begin
            // HOFF with brake: both sides held on
            bus.brake = 1'b1;
            #1;
            checks++;
            if (lamp_l !== 3'b111 || lamp_r !== 3'b111) begin
               $display("FAIL hazard_brake: got l=%b r=%b, want l=111 r=111", lamp_l, lamp_r);
               errors++;
            end
            bus.brake = 1'b0;
            #1;
         end
         do_chk   = 1'b1;
         exp_busy = 1'b1;
         case (e)
            8:  begin exp_l = 3'b110; exp_r = 3'b000; end
            12: begin exp_l = 3'b111; exp_r = 3'b111; end
            14: begin exp_l = 3'b111; exp_r = 3'b111; end
            16: begin exp_l = 3'b000; exp_r = 3'b000; end
            20: begin exp_l = 3'b111; exp_r = 3'b111; end
            24: begin exp_l = 3'b000; exp_r = 3'b000; end
            28: begin exp_l = 3'b000; exp_r = 3'b000; exp_busy = 1'b0; end
            default: begin exp_l = 3'b000; exp_r = 3'b000; do_chk = 1'b0; end
         endcase
         if (do_chk) begin
            checks++;
            if (lamp_l !== exp_l || lamp_r !== exp_r || bus.busy !== exp_busy) begin
               $display("FAIL hazard_abort edge %0d: got l=%b r=%b busy=%b, want l=%b r=%b busy=%b",
                        e, lamp_l, lamp_r, bus.busy, exp_l, exp_r, exp_busy);
               errors++;
            end
         end
      end
   endtask

   task automatic test_both_requests();
      logic [2:0] exp_lamps;
      logic       exp_busy;
      apply_reset();
      bus.left  = 1'b1;
      bus.right = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         wait_edges(1);
         if (e == 9) begin
            bus.left  = 1'b0;
            bus.right = 1'b0;
         end
         if (e % 4 == 0) begin
            exp_lamps = (e == 4) ? 3'b111 : 3'b000;
            exp_busy  = (e != 12);
            checks++;
            if (lamp_l !== exp_lamps || lamp_r !== exp_lamps || bus.busy !== exp_busy) begin
               $display("FAIL both_requests edge %0d: got l=%b r=%b busy=%b, want l=%b r=%b busy=%b",
                        e, lamp_l, lamp_r, bus.busy, exp_lamps, exp_lamps, exp_busy);
               errors++;
            end
         end
      end
   endtask

   task automatic test_brake();
      apply_reset();
      wait_edges(1);
      bus.brake = 1'b1;
      #1;
      checks++;
      if (lamp_l !== 3'b111 || lamp_r !== 3'b111 || bus.busy !== 1'b0) begin
         $display("FAIL brake_idle: got l=%b r=%b busy=%b, want l=111 r=111 busy=0",
                  lamp_l, lamp_r, bus.busy);
         errors++;
      end
      bus.brake = 1'b0;
      #1;
      checks++;
      if (lamp_l !== 3'b000 || lamp_r !== 3'b000) begin
         $display("FAIL brake_release: got l=%b r=%b, want l=000 r=000", lamp_l, lamp_r);
         errors++;
      end
      bus.left = 1'b1;
      wait_edges(7);  // edge 8: L2
      bus.brake = 1'b1;
      #1;
      checks++;
      if (lamp_l !== 3'b110 || lamp_r !== 3'b111) begin
         $display("FAIL brake_sweep: got l=%b r=%b, want l=110 r=111", lamp_l, lamp_r);
         errors++;
      end
      bus.brake = 1'b0;
      #1;
      checks++;
      if (lamp_l !== 3'b110 || lamp_r !== 3'b000) begin
         $display("FAIL brake_sweep_release: got l=%b r=%b, want l=110 r=000", lamp_l, lamp_r);
         errors++;
      end
      bus.left = 1'b0;
   endtask

   task automatic test_short_pulse();
      apply_reset();
      for (int e = 1; e <= 8; e++) begin
         wait_edges(1);
         if (e == 1) bus.left = 1'b1;
         if (e == 2) bus.left = 1'b0;
         if (e == 4 || e == 8) begin
            checks++;
            if (lamp_l !== 3'b000 || bus.busy !== 1'b0) begin
               $display("FAIL short_pulse edge %0d: got l=%b busy=%b, want l=000 busy=0",
                        e, lamp_l, bus.busy);
               errors++;
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.left = 1'b1;
      wait_edges(8);
      checks++;
      if (lamp_l !== 3'b110) begin
         $display("FAIL reset_mid_pre: got l=%b, want l=110", lamp_l);
         errors++;
      end
      wait_edges(1);
      reset = 1'b1;
      wait_edges(1);
      checks++;
      if (lamp_l !== 3'b000 || lamp_r !== 3'b000 || bus.busy !== 1'b0) begin
         $display("FAIL reset_mid: got l=%b r=%b busy=%b, want l=000 r=000 busy=0",
                  lamp_l, lamp_r, bus.busy);
         errors++;
      end
      reset = 1'b0;
      wait_edges(4);
      checks++;
      if (lamp_l !== 3'b100 || bus.busy !== 1'b1) begin
         $display("FAIL reset_mid_restart: got l=%b busy=%b, want l=100 busy=1",
                  lamp_l, bus.busy);
         errors++;
      end
      bus.left = 1'b0;
   endtask

   task automatic test_tick_div_one();
      logic [2:0] exp_l;
      reset_fast = 1'b1;
      wait_edges(2);
      reset_fast    = 1'b0;
      bus_fast.left = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         wait_edges(1);
         case (e)
            1:       exp_l = 3'b100;
            2:       exp_l = 3'b110;
            3:       exp_l = 3'b111;
            4:       exp_l = 3'b000;
            default: exp_l = 3'b100;
         endcase
         checks++;
         if (fast_l !== exp_l || fast_r !== 3'b000 || bus_fast.busy !== (e != 4)) begin
            $display("FAIL tick_div_one edge %0d: got l=%b r=%b busy=%b, want l=%b r=000 busy=%b",
                     e, fast_l, fast_r, bus_fast.busy, exp_l, (e != 4));
            errors++;
         end
      end
      bus_fast.left = 1'b0;
   endtask

   initial begin
      bus.left        = 1'b0;
      bus.right       = 1'b0;
      bus.hazard      = 1'b0;
      bus.brake       = 1'b0;
      bus_fast.left   = 1'b0;
      bus_fast.right  = 1'b0;
      bus_fast.hazard = 1'b0;
      bus_fast.brake  = 1'b0;

      test_reset();
      test_left_sweep();
      test_request_drop();
      test_hazard_abort();
      test_both_requests();
      test_brake();
      test_short_pulse();
      test_reset_mid();
      test_tick_div_one();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
